dmem_arbiter: RTL and testbench

Two-requester arbiter for the single data-memory/memory-mapped-I/O port. It shares that port between the CPU load/store path and a debug/DMA requester. The CPU has fixed priority, with a starvation counter that bounds how long the debug port can be denied. An optional debug lock gives the debug port bounded atomic ownership. The block sits between the CPU datapath and the data memory; its `cpu_stall` output holds the PC write-enable low while the CPU is denied.

---
 rtl/dmem_arbiter_if.sv | 59 +++++
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the CPU request path, the debug/DMA request path
// and the data-memory port that dmem_arbiter shares between them.
//
// Modports:
//   slave  - the arbiter: takes requests and mem_rdata, drives grants,
//            read-valid strobes, dbg_err and the memory port
//   master - the surroundings (CPU datapath, debug port, data memory)
//
// Signal groups:
//   cpu_*  : cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_gnt, cpu_stall, cpu_rvalid
//   dbg_*  : dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata
//            -> dbg_gnt, dbg_rvalid, dbg_err
//   mem_*  : mem_we, mem_addr, mem_wdata out; mem_rdata in; rdata mirrors mem_rdata
interface dmem_arbiter_if #(
    parameter int DBITS = 32
);
    logic             cpu_req;
    logic             cpu_we;
    logic [DBITS-1:0] cpu_addr;
    logic [DBITS-1:0] cpu_wdata;
    logic             cpu_gnt;
    logic             cpu_stall;
    logic             cpu_rvalid;

    logic             dbg_req;
    logic             dbg_we;
    logic             dbg_lock;
    logic [DBITS-1:0] dbg_addr;
    logic [DBITS-1:0] dbg_wdata;
    logic             dbg_gnt;
    logic             dbg_rvalid;
    logic             dbg_err;

    logic             mem_we;
    logic [DBITS-1:0] mem_addr;
    logic [DBITS-1:0] mem_wdata;
    logic [DBITS-1:0] mem_rdata;
    logic [DBITS-1:0] rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid,
        input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_err,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid,
        output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_err,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory / MMIO port between the CPU
// load/store path and a debug/DMA requester.
//
// The CPU has fixed priority. A starvation counter force-grants debug after
// STARVE_LIMIT consecutive denied debug-request cycles. A debug grant with
// dbg_lock high gives debug exclusive ownership for at most LOCK_MAX cycles;
// once that runs out the lock cannot be re-taken until dbg_lock drops.
//
// Ports:
//   clk    - system clock, all state on the rising edge
//   reset  - asynchronous, active-low reset (also forces grants off while low)
//   bus    - dmem_arbiter_if.slave (requests, grants, memory port, read data)
//
// Parameters: DBITS (address/data width), STARVE_LIMIT (>=1), LOCK_MAX (>=1)
//
// Optional feature macro: DMEM_ARB_IO_PROTECT_EN
//   defined   - granted debug writes to the I/O region (top nibble 4'hF) are
//               dropped (mem_we forced low) and dbg_err pulses the next cycle
//   undefined - such writes pass through, dbg_err is tied low
module dmem_arbiter #(
    parameter int DBITS        = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 16
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        LOCKED  = 2'd1,
        EXPIRED = 2'd2
    } arb_state_t;

    arb_state_t    state;
    logic [SW-1:0] starve_cnt;
    logic [LW-1:0] lock_cnt;
    logic          cpu_rd_pending;
    logic          dbg_rd_pending;

    logic          cpu_gnt_c;
    logic          dbg_gnt_c;
    logic          io_block;

    // Grant selection. LOCKED hands the port to debug only and keeps the CPU
    // out even when debug is idle; NORMAL and EXPIRED share the CPU-priority
    // rule with the starvation override. Reset low masks every grant so a
    // request in a reset cycle never reaches memory.
    always_comb begin
        cpu_gnt_c = 1'b0;
        dbg_gnt_c = 1'b0;
        if (reset) begin
            if (state == LOCKED) begin
                dbg_gnt_c = bus.dbg_req;
            end else if ((starve_cnt == STARVE_MAX) && bus.dbg_req) begin
                dbg_gnt_c = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_gnt_c = 1'b1;
            end else begin
                dbg_gnt_c = bus.dbg_req;
            end
        end
    end

`ifdef DMEM_ARB_IO_PROTECT_EN
    // A granted debug write into the I/O region is swallowed here.
    assign io_block = dbg_gnt_c & bus.dbg_we & (bus.dbg_addr[DBITS-1 -: 4] == 4'hF);
`else
    assign io_block = 1'b0;
`endif

    assign bus.cpu_gnt    = cpu_gnt_c;
    assign bus.dbg_gnt    = dbg_gnt_c;
    assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt_c;
    assign bus.mem_addr   = dbg_gnt_c ? bus.dbg_addr  : bus.cpu_addr;
    assign bus.mem_wdata  = dbg_gnt_c ? bus.dbg_wdata : bus.cpu_wdata;
    assign bus.mem_we     = (cpu_gnt_c & bus.cpu_we) |
                            (dbg_gnt_c & bus.dbg_we & ~io_block);
    assign bus.rdata      = bus.mem_rdata;
    assign bus.cpu_rvalid = cpu_rd_pending;
    assign bus.dbg_rvalid = dbg_rd_pending;

`ifdef DMEM_ARB_IO_PROTECT_EN
    logic dbg_err_q;
    assign bus.dbg_err = dbg_err_q;
`else
    assign bus.dbg_err = 1'b0;
`endif

    // Arbitration state, starvation/lock counters and the registered read
    // owner flags. The owner flags turn a granted read into a one-cycle
    // rvalid pulse on the matching requester in the next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= NORMAL;
            starve_cnt     <= '0;
            lock_cnt       <= '0;
            cpu_rd_pending <= 1'b0;
            dbg_rd_pending <= 1'b0;
`ifdef DMEM_ARB_IO_PROTECT_EN
            dbg_err_q      <= 1'b0;
`endif
        end else begin
            cpu_rd_pending <= cpu_gnt_c & ~bus.cpu_we;
            dbg_rd_pending <= dbg_gnt_c & ~bus.dbg_we;
`ifdef DMEM_ARB_IO_PROTECT_EN
            dbg_err_q      <= io_block;
`endif

            if (bus.dbg_req && !dbg_gnt_c) begin
                if (starve_cnt != STARVE_MAX) begin
                    starve_cnt <= starve_cnt + SW'(1);
                end
            end else begin
                starve_cnt <= '0;
            end

            case (state)
                NORMAL: begin
                    if (dbg_gnt_c && bus.dbg_lock) begin
                        state    <= LOCKED;
                        lock_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (!bus.dbg_lock) begin
                        state <= NORMAL;
                    end else if (lock_cnt == LOCK_LAST) begin
                        state <= EXPIRED;
                    end else begin
                        lock_cnt <= lock_cnt + LW'(1);
                    end
                end
                EXPIRED: begin
                    // A lock that timed out must be released before it can
                    // be taken again.
                    if (!bus.dbg_lock) begin
                        state <= NORMAL;
                    end
                end
                default: begin
                    state <= NORMAL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed literal checks for the documented scenarios,
// then randomized traffic compared every cycle against a behavioural model.
module tb_dmem_arbiter;
    localparam int DBITS        = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int LOCK_MAX     = 16;
`ifdef DMEM_ARB_IO_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    logic clk;
    logic reset;
    int   testsRun = 0;
    int   testsFailed = 0;

    dmem_arbiter_if #(.DBITS(DBITS)) bus ();

    dmem_arbiter #(
        .DBITS(DBITS),
        .STARVE_LIMIT(STARVE_LIMIT),
        .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: how long debug has waited, whether debug owns the
    // port under a lock and for how long, whether an expired lock is still
    // held, and which reads/blocked writes are owed a response next cycle.
    int mWaited = 0;
    bit mLockOwned = 0;
    int mLockAge = 0;
    bit mLockSpent = 0;
    bit mCpuReadOwed = 0;
    bit mDbgReadOwed = 0;
    bit mErrOwed = 0;

    function automatic bit isIo(input logic [DBITS-1:0] a);
        logic [DBITS-1:0] t;
        t = a;
        return t[31:28] == 4'hF;
    endfunction

    task automatic predict(output bit eCpu, output bit eDbg);
        eCpu = 0;
        eDbg = 0;
        if (reset !== 1'b1) return;
        if (mLockOwned) begin
            eDbg = bus.dbg_req;
        end else if (bus.dbg_req && mWaited >= STARVE_LIMIT) begin
            eDbg = 1;
        end else if (bus.cpu_req) begin
            eCpu = 1;
        end else begin
            eDbg = bus.dbg_req;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        bit eCpu, eDbg;
        if (!reset) begin
            mWaited = 0; mLockOwned = 0; mLockAge = 0; mLockSpent = 0;
            mCpuReadOwed = 0; mDbgReadOwed = 0; mErrOwed = 0;
        end else begin
            predict(eCpu, eDbg);
            mCpuReadOwed = eCpu && !bus.cpu_we;
            mDbgReadOwed = eDbg && !bus.dbg_we;
            mErrOwed = PROTECT && eDbg && bus.dbg_we && isIo(bus.dbg_addr);
            mWaited = (bus.dbg_req && !eDbg) ? ((mWaited + 1 > STARVE_LIMIT) ? STARVE_LIMIT : mWaited + 1) : 0;
            if (mLockOwned) begin
                mLockAge++;
                if (!bus.dbg_lock) mLockOwned = 0;
                else if (mLockAge >= LOCK_MAX) begin
                    mLockOwned = 0;
                    mLockSpent = 1;
                end
            end else if (mLockSpent) begin
                if (!bus.dbg_lock) mLockSpent = 0;
            end else if (eDbg && bus.dbg_lock) begin
                mLockOwned = 1;
                mLockAge = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [DBITS-1:0] actual,
                               input logic [DBITS-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: every cycle, mid-cycle, DUT outputs against the model.
    always @(negedge clk) begin
        bit eCpu, eDbg;
        logic [DBITS-1:0] eAddr, eWdata;
        bit eWe;
        predict(eCpu, eDbg);
        eAddr  = eDbg ? bus.dbg_addr : bus.cpu_addr;
        eWdata = eDbg ? bus.dbg_wdata : bus.cpu_wdata;
        eWe    = (eCpu && bus.cpu_we) ||
                 (eDbg && bus.dbg_we && !(PROTECT && isIo(bus.dbg_addr)));
        checkOutput("model cpu_gnt", 32'(bus.cpu_gnt), 32'(eCpu));
        checkOutput("model dbg_gnt", 32'(bus.dbg_gnt), 32'(eDbg));
        checkOutput("model cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && !eCpu));
        checkOutput("model mem_we", 32'(bus.mem_we), 32'(eWe));
        checkOutput("model mem_addr", bus.mem_addr, eAddr);
        checkOutput("model mem_wdata", bus.mem_wdata, eWdata);
        checkOutput("model cpu_rvalid", 32'(bus.cpu_rvalid), 32'(mCpuReadOwed && reset));
        checkOutput("model dbg_rvalid", 32'(bus.dbg_rvalid), 32'(mDbgReadOwed && reset));
        checkOutput("model dbg_err", 32'(bus.dbg_err), 32'(mErrOwed && reset));
        checkOutput("model rdata", bus.rdata, bus.mem_rdata);
    end

    task automatic applyStimulus(input bit cReq, input bit cWe, input logic [31:0] cAddr,
                                 input logic [31:0] cWd, input bit dReq, input bit dWe,
                                 input bit dLock, input logic [31:0] dAddr,
                                 input logic [31:0] dWd, input logic [31:0] rd);
        bus.cpu_req   = cReq;
        bus.cpu_we    = cWe;
        bus.cpu_addr  = cAddr;
        bus.cpu_wdata = cWd;
        bus.dbg_req   = dReq;
        bus.dbg_we    = dWe;
        bus.dbg_lock  = dLock;
        bus.dbg_addr  = dAddr;
        bus.dbg_wdata = dWd;
        bus.mem_rdata = rd;
    endtask

    // Advance to just after the next rising edge, then drive.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit lockVal;
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        checkOutput("reset dbg_err", 32'(bus.dbg_err), 32'd0);
        nextCycle();
        reset = 1'b1;

        // CPU read of 0x100, memory answers 0xDEADBEEF next cycle.
        nextCycle();
        applyStimulus(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("read cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        checkOutput("read mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("read mem_addr", bus.mem_addr, 32'h100);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("read cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        checkOutput("read rdata", bus.rdata, 32'hDEADBEEF);
        checkOutput("read dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);

        // CPU write 0x5A to 0x200: strobe now, no rvalid afterwards.
        nextCycle();
        applyStimulus(1, 1, 32'h200, 32'h5A, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("write mem_we", 32'(bus.mem_we), 32'd1);
        checkOutput("write mem_addr", bus.mem_addr, 32'h200);
        checkOutput("write mem_wdata", bus.mem_wdata, 32'h5A);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("write no rvalid", 32'(bus.cpu_rvalid), 32'd0);

        // Both requesting with dbg_lock held: C C C C then forced D takes the
        // lock for 16 more cycles, then EXPIRED: C C C C, forced D (no relock), C.
        for (int i = 0; i < 27; i++) begin
            bit wantDbg;
            nextCycle();
            applyStimulus(1, 0, 32'h40, 0, 1, 0, 1, 32'h80, 0, 0);
            wantDbg = (i >= 4 && i <= 20) || (i == 25);
            @(negedge clk);
            checkOutput($sformatf("lock seq cpu_gnt[%0d]", i), 32'(bus.cpu_gnt), 32'(!wantDbg));
            checkOutput($sformatf("lock seq dbg_gnt[%0d]", i), 32'(bus.dbg_gnt), 32'(wantDbg));
            checkOutput($sformatf("lock seq cpu_stall[%0d]", i), 32'(bus.cpu_stall), 32'(wantDbg));
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Debug write into the I/O region.
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 32'hF0000004, 32'h77, 0);
        @(negedge clk);
        checkOutput("io dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
        checkOutput("io mem_we", 32'(bus.mem_we), PROTECT ? 32'd0 : 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("io dbg_err", 32'(bus.dbg_err), PROTECT ? 32'd1 : 32'd0);
        checkOutput("io no dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);

        // Reset right after a granted read kills the response.
        nextCycle();
        applyStimulus(1, 0, 32'h300, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rst read cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        nextCycle();
        reset = 1'b0;
        applyStimulus(1, 0, 32'h300, 0, 1, 0, 0, 32'h10, 0, 0);
        @(negedge clk);
        checkOutput("rst cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        checkOutput("rst cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
        nextCycle();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("post rst cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        checkOutput("post rst dbg_gnt", 32'(bus.dbg_gnt), 32'd0);

        // Randomized traffic; the compare process checks every cycle.
        lockVal = 0;
        for (int i = 0; i < 800; i++) begin
            logic [31:0] dAddr;
            nextCycle();
            if ($urandom_range(19) == 0) lockVal = ~lockVal;
            dAddr = $urandom;
            if ($urandom_range(3) == 0) dAddr[31:28] = 4'hF;
            applyStimulus($urandom_range(99) < 70, $urandom_range(1) == 1, $urandom, $urandom,
                          $urandom_range(99) < 50, $urandom_range(1) == 1, lockVal,
                          dAddr, $urandom, $urandom);
            if ($urandom_range(299) == 0) reset = 1'b0;
            else reset = 1'b1;
        end
        nextCycle();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
